// File: rtl/rgb_pwm_pkg.sv
// Shared mode encoding and FSM state type for the RGB PWM LED controller.
package rgb_pwm_pkg;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_SOLID   = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_SOLID     = 3'd1,
      S_BLINK_ON  = 3'd2,
      S_BLINK_OFF = 3'd3,
      S_BREATHE   = 3'd4
   } state_t;

   function automatic state_t entry_state(input logic [1:0] m);
      case (m)
         MODE_SOLID:   return S_SOLID;
         MODE_BLINK:   return S_BLINK_ON;
         MODE_BREATHE: return S_BREATHE;
         default:      return S_OFF;
      endcase
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: duty compare against the shared PWM counter and registered pin drive.
module pwm_channel #(
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic [PWM_BITS-1:0] eff_duty,
   output logic                led
);

   logic lit;
   logic led_d, led_q;

   // All-ones duty must stay lit through the last count of the period as well.
   always_comb begin
      lit   = (eff_duty == '1) || (pwm_cnt < eff_duty);
      led_d = lit ^ ACTIVE_LOW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_q <= ACTIVE_LOW;
      else        led_q <= led_d;
   end

   assign led = led_q;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB LED PWM controller: shared prescaler, PWM counter and mode FSM driving N_CH channels.
// Optional BREATHE ramp/multiplier enabled by macro RGB_PWM_BREATHE_EN.
//
// state       | meaning
// S_OFF       | all channels dark
// S_SOLID     | latched duty on every period
// S_BLINK_ON  | latched duty, counting BLINK_PERIODS periods
// S_BLINK_OFF | dark, counting BLINK_PERIODS periods
// S_BREATHE   | latched duty scaled by triangle ramp
module rgb_pwm_ctrl
   import rgb_pwm_pkg::*;
#(
   parameter int N_CH          = 3,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE      = 64,
   parameter int BLINK_PERIODS = 128,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               mode,
   input  logic [N_CH*PWM_BITS-1:0] duty,
   output logic [N_CH-1:0]          led,
   output logic                     period_start
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_PERIODS - 1);

   logic [PS_W-1:0]          presc_d, presc_q;
   logic                     tick;
   logic [PWM_BITS-1:0]      pwm_cnt_d, pwm_cnt_q;
   logic [N_CH*PWM_BITS-1:0] duty_lat_d, duty_lat_q;
   logic [1:0]               mode_in, mode_d, mode_q;
   state_t                   state_d, state_q;
   logic [BL_W-1:0]          blink_cnt_d, blink_cnt_q;
   logic [N_CH*PWM_BITS-1:0] eff_duty;

   always_comb begin
      tick         = (presc_q == PS_LAST);
      presc_d      = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d    = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
      period_start = tick && (pwm_cnt_q == '1);
   end

`ifdef RGB_PWM_BREATHE_EN
   assign mode_in = mode;
`else
   // Without the breathe hardware, BREATHE is treated as the same mode as SOLID.
   assign mode_in = (mode == MODE_BREATHE) ? MODE_SOLID : mode;
`endif

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      duty_lat_d  = duty_lat_q;
      blink_cnt_d = blink_cnt_q;
      if (period_start) begin
         duty_lat_d = duty;
         mode_d     = mode_in;
         if (mode_in != mode_q) begin
            state_d     = entry_state(mode_in);
            blink_cnt_d = '0;
         end else if (state_q == S_BLINK_ON || state_q == S_BLINK_OFF) begin
            if (blink_cnt_q == BL_LAST) begin
               blink_cnt_d = '0;
               state_d     = (state_q == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         pwm_cnt_q   <= '0;
         duty_lat_q  <= '0;
         mode_q      <= MODE_OFF;
         state_q     <= S_OFF;
         blink_cnt_q <= '0;
      end else begin
         presc_q     <= presc_d;
         pwm_cnt_q   <= pwm_cnt_d;
         duty_lat_q  <= duty_lat_d;
         mode_q      <= mode_d;
         state_q     <= state_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

`ifdef RGB_PWM_BREATHE_EN
   logic [PWM_BITS-1:0]   ramp_d, ramp_q;
   logic                  ramp_up_d, ramp_up_q;
   logic [2*PWM_BITS-1:0] prod;

   // Triangle ramp: direction flips on reaching either end so each end is held one period.
   always_comb begin
      ramp_d    = ramp_q;
      ramp_up_d = ramp_up_q;
      if (period_start) begin
         if (mode_in != mode_q) begin
            ramp_d    = '0;
            ramp_up_d = 1'b1;
         end else if (state_q == S_BREATHE) begin
            if (ramp_up_q) begin
               ramp_d = ramp_q + 1'b1;
               if (ramp_d == '1) ramp_up_d = 1'b0;
            end else begin
               ramp_d = ramp_q - 1'b1;
               if (ramp_d == '0) ramp_up_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramp_q    <= '0;
         ramp_up_q <= 1'b1;
      end else begin
         ramp_q    <= ramp_d;
         ramp_up_q <= ramp_up_d;
      end
   end
`endif

   always_comb begin
      eff_duty = '0;
`ifdef RGB_PWM_BREATHE_EN
      prod = '0;
`endif
      for (int i = 0; i < N_CH; i++) begin
         case (state_q)
            S_SOLID, S_BLINK_ON: eff_duty[i*PWM_BITS +: PWM_BITS] = duty_lat_q[i*PWM_BITS +: PWM_BITS];
`ifdef RGB_PWM_BREATHE_EN
            S_BREATHE: begin
               prod = {{PWM_BITS{1'b0}}, duty_lat_q[i*PWM_BITS +: PWM_BITS]} * {{PWM_BITS{1'b0}}, ramp_q};
               eff_duty[i*PWM_BITS +: PWM_BITS] = PWM_BITS'(prod >> PWM_BITS);
            end
`endif
            default: eff_duty[i*PWM_BITS +: PWM_BITS] = '0;
         endcase
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .pwm_cnt  (pwm_cnt_q),
         .eff_duty (eff_duty[g*PWM_BITS +: PWM_BITS]),
         .led      (led[g])
      );
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: per-period waveform checks against a period-level behavioural model.
module tb_rgb_pwm_ctrl;

   localparam int N_CH          = 3;
   localparam int PWM_BITS      = 4;
   localparam int PRESCALE      = 1;
   localparam int BLINK_PERIODS = 2;
   localparam int DMAX          = (1 << PWM_BITS) - 1;
   localparam int PERIOD_CLKS   = PRESCALE * (1 << PWM_BITS);
`ifdef RGB_PWM_BREATHE_EN
   localparam bit BREATHE_EN = 1'b1;
`else
   localparam bit BREATHE_EN = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [1:0]               mode = 2'd0;
   logic [N_CH*PWM_BITS-1:0] duty = '0;
   logic [N_CH-1:0]          led;
   logic                     period_start;

   int errors = 0;
   int checks = 0;
   int pidx = 0;
   int m_mode, m_k;
   int cur_eff [N_CH];
   int next_eff [N_CH];

   always #5 clk = ~clk;

   rgb_pwm_ctrl #(
      .N_CH          (N_CH),
      .PWM_BITS      (PWM_BITS),
      .PRESCALE      (PRESCALE),
      .BLINK_PERIODS (BLINK_PERIODS),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode         (mode),
      .duty         (duty),
      .led          (led),
      .period_start (period_start)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Period-level model: count periods since mode entry, derive blink phase and ramp from it.
   task automatic model_sample();
      int nm, d, r, ramp, e;
      nm = int'(mode);
      if (!BREATHE_EN && nm == 3) nm = 1;
      if (nm != m_mode) begin
         m_mode = nm;
         m_k    = 0;
      end else begin
         m_k++;
      end
      r    = m_k % (2 * DMAX);
      ramp = (r <= DMAX) ? r : (2 * DMAX - r);
      for (int c = 0; c < N_CH; c++) begin
         d = int'(duty[c*PWM_BITS +: PWM_BITS]);
         case (m_mode)
            0:       e = 0;
            1:       e = d;
            2:       e = (((m_k / BLINK_PERIODS) % 2) == 0) ? d : 0;
            default: e = (d * ramp) >> PWM_BITS;
         endcase
         next_eff[c] = e;
      end
   endtask

   task automatic start_after_reset();
      int n;
      logic dark;
      m_mode = 0;
      m_k    = 0;
      @(negedge clk);
      rst_n = 1'b1;
      n     = 0;
      dark  = 1'b1;
      while (period_start !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
         if (led !== 3'b111) dark = 1'b0;
      end
      // n negedges until the pulse is seen; the pulse is consumed on the following edge.
      check("first_ps_clks", n + 1, PERIOD_CLKS);
      check("dark_until_first_ps", dark, 1'b1);
      model_sample();
      @(negedge clk);
      check("dark_last_off_clk", led, 3'b111);
      cur_eff = next_eff;
   endtask

   task automatic do_period(input logic [1:0] nm, input logic [N_CH*PWM_BITS-1:0] nd, input int chg_j);
      logic [15:0] pat [N_CH];
      logic [15:0] ps_pat;
      logic [15:0] exp_pat;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         for (int c = 0; c < N_CH; c++) pat[c][j-1] = ~led[c];
         ps_pat[j-1] = period_start;
         if (j == chg_j) begin
            mode = nm;
            duty = nd;
         end
         if (j == 15) model_sample();
      end
      check($sformatf("p%0d_period_start", pidx), ps_pat, 16'h4000);
      for (int c = 0; c < N_CH; c++) begin
         exp_pat = (cur_eff[c] == DMAX) ? 16'hFFFF : 16'((1 << cur_eff[c]) - 1);
         check($sformatf("p%0d_led%0d", pidx, c), pat[c], exp_pat);
      end
      cur_eff = next_eff;
      pidx++;
   endtask

   initial begin
      logic [1:0] rmode;
      mode  = 2'd1;
      duty  = {4'd0, 4'd15, 4'd4};
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_led", led, 3'b111);
      check("rst_period_start", period_start, 1'b0);
      start_after_reset();

      // SOLID 4/15/0, then ch0 changed mid-period from 4 to 12
      do_period(2'd1, {4'd0, 4'd15, 4'd4}, 15);
      do_period(2'd1, {4'd0, 4'd15, 4'd12}, 5);
      do_period(2'd1, {4'd0, 4'd15, 4'd12}, 15);

      // BLINK at 8 on all channels
      do_period(2'd2, {4'd8, 4'd8, 4'd8}, 7);
      repeat (9) do_period(2'd2, {4'd8, 4'd8, 4'd8}, 15);

      // BREATHE at 15 for more than one full ramp
      do_period(2'd3, {4'd15, 4'd15, 4'd15}, 3);
      repeat (33) do_period(2'd3, {4'd15, 4'd15, 4'd15}, 15);

      // randomized modes, duties and change points
      rmode = 2'd1;
      repeat (40) begin
         if ($urandom_range(0, 3) == 0) rmode = 2'($urandom_range(0, 3));
         do_period(rmode, 12'($urandom), $urandom_range(1, 15));
      end

      // asynchronous reset in the middle of a lit blink period
      do_period(2'd0, 12'h000, 15);
      do_period(2'd2, 12'hFFF, 15);
      @(posedge clk);
      #2;
      check("pre_rst_lit", led, 3'b000);
      rst_n = 1'b0;
      #1;
      check("async_rst_led", led, 3'b111);
      check("async_rst_ps", period_start, 1'b0);
      start_after_reset();
      repeat (5) do_period(2'd2, 12'hFFF, 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of LED channels (ch0=red, ch1=green, ch2=blue).
REQ-002 SHALL have parameter PWM_BITS, default 8, duty resolution.
REQ-003 SHALL have parameter PRESCALE, default 64, clk cycles per PWM count tick (>=1).
REQ-004 SHALL have parameter BLINK_PERIODS, default 128, PWM periods per blink half-cycle (>=1).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1, LED drive polarity (1: pin 0 = LED lit).
REQ-006 SHALL have port clk, input, 1, single system clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port mode, input, 2, 0=OFF 1=SOLID 2=BLINK 3=BREATHE.
REQ-009 SHALL have port duty, input, N_CH*PWM_BITS, packed per-channel duty, ch0 in LSBs.
REQ-010 SHALL have port led, output, N_CH, registered LED pins.
REQ-011 SHALL have port period_start, output, 1, one-clk pulse at each PWM period start.

Function
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and assert tick for one clk at PRESCALE-1, then wrap to 0.
REQ-013 PWM counter (PWM_BITS wide) SHALL increment on tick and wrap from 2^PWM_BITS-1 to 0; the wrap tick SHALL assert period_start in that same clk.
REQ-014 duty and mode SHALL be sampled only on period_start; mid-period changes SHALL have no effect until the next period.
REQ-015 Channel lit SHALL equal (pwm_cnt < eff_duty), except eff_duty all-ones SHALL light continuously; eff_duty 0 SHALL never light.
REQ-016 led[i] SHALL equal lit[i] XOR ACTIVE_LOW, registered, one clk after pwm_cnt update.
REQ-017 FSM states: S_OFF, S_SOLID, S_BLINK_ON, S_BLINK_OFF, S_BREATHE; transitions only on period_start.
REQ-018 S_OFF: eff_duty=0 all channels. S_SOLID: eff_duty=latched duty.
REQ-019 Entering BLINK SHALL go to S_BLINK_ON; S_BLINK_ON/OFF SHALL alternate after BLINK_PERIODS periods each; blink counter SHALL clear on any mode change.
REQ-020 S_BLINK_ON uses latched duty; S_BLINK_OFF uses 0.
REQ-021 S_BREATHE: ramp register (PWM_BITS) SHALL step +1 per period to all-ones, then -1 to 0, repeating; eff_duty = (duty*ramp) >> PWM_BITS, full-width product, no overflow.
REQ-022 Mode change to same mode SHALL not restart blink/ramp counters.

Reset
REQ-023 While rst_n=0: all counters, ramp, latched duty = 0; state S_OFF; period_start=0; led = all ACTIVE_LOW (all LEDs dark).
REQ-024 Reset assertion mid-period SHALL force dark outputs immediately (asynchronous); first period_start after release occurs after exactly PRESCALE*2^PWM_BITS clks.

Configuration
REQ-025 Macro RGB_PWM_BREATHE_EN defined: BREATHE mode and ramp/multiplier logic present per REQ-021.
REQ-026 Macro undefined: no ramp or multiplier hardware; mode=3 SHALL behave exactly as SOLID.

Structure
REQ-027 Package rgb_pwm_pkg SHALL hold the mode encoding constants and the FSM state typedef.
REQ-028 Per-channel compare/polarity logic SHALL be sub-module pwm_channel, instantiated N_CH times; prescaler, PWM counter and FSM shared at top.

Verification (PRESCALE=1, PWM_BITS=4, BLINK_PERIODS=2, ACTIVE_LOW=1 unless stated)
REQ-029 Reset then mode=SOLID, duty ch0=4 -> after first period_start, led[0]=0 for 4 of every 16 clks, led[1:2]=1.
REQ-030 duty ch1=15 SOLID -> led[1] constantly 0; duty ch2=0 -> led[2] constantly 1.
REQ-031 mode=BLINK, duty all 8 -> 2 periods at 8/16 lit, 2 periods dark, repeating (64-clk cycle).
REQ-032 duty changed mid-period from 4 to 12 -> current period keeps 4, next period shows 12; period_start every 16 clks.
REQ-033 RGB_PWM_BREATHE_EN on, mode=3, duty=15 -> per-period lit count follows (15*ramp)>>4, ramp 0..15..0; macro off -> constant 15-lit-equivalent as SOLID.
REQ-034 rst_n pulled low mid-blink -> led=3'b111 within same clk, state S_OFF after release until first period_start.
